// File: rtl/button_step_reader_pkg.sv
// Board constants and shared types for the push-button step reader.
package button_step_reader_pkg;

  localparam int unsigned CLK_HZ = 12000000;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  function automatic logic [3:0] led_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM producing a clean level and
// one-cycle press/release pulses.
module btn_debounce
  import button_step_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 50,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output btn_state_t state,
  output logic       accept_press,
  output logic       accept_release,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse
);

  localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic       IDLE_LVL = ACTIVE_LOW;

  logic          s1, s2;
  logic          sync_p;
  logic          at_max;
  logic [DW-1:0] cnt;

  assign sync_p = s2 ^ IDLE_LVL;
  assign at_max = (cnt == DEB_MAX);
  // Exported so the top can step the index in the same cycle the pulse rises.
  assign accept_press   = (state == PRESS_WAIT) && sync_p && at_max;
  assign accept_release = (state == REL_WAIT) && !sync_p && at_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1            <= IDLE_LVL;
      s2            <= IDLE_LVL;
      state         <= RELEASED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= btn_raw;
      s2            <= s1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (sync_p) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_p) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (accept_press) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!sync_p) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        end
        REL_WAIT: begin
          if (sync_p) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (accept_release) begin
            state         <= RELEASED;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_step_reader.sv
// Debounced push-button stepping a one-hot LED index, with long-press
// detection and auto-repeat while held.
module button_step_reader
  import button_step_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 50,
  parameter int unsigned LONG_CYCLES     = CLK_HZ,
  parameter int unsigned REPEAT_CYCLES   = CLK_HZ / 4,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] step_idx,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5
);

  localparam int unsigned HW = $clog2(LONG_CYCLES);
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 2);
  localparam logic [RW-1:0] REP_MAX   = RW'(REPEAT_CYCLES - 1);

  btn_state_t    state;
  logic          accept_press;
  logic          accept_release;
  logic [HW-1:0] hold;
  logic [RW-1:0] rep;
  logic          rep_tick;
  logic [1:0]    step_next;
  logic [3:0]    leds;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_debounce (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .state         (state),
    .accept_press  (accept_press),
    .accept_release(accept_release),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always_comb begin
    rep_tick  = (state == PRESSED) && (hold == HOLD_MAX) && (rep == REP_MAX);
    step_next = step_idx + {1'b0, (accept_press || rep_tick)};
  end

  // Hold/repeat timing advances only in PRESSED, so REL_WAIT bounces pause it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold       <= '0;
      rep        <= '0;
      long_pulse <= 1'b0;
      step_idx   <= '0;
      leds       <= 4'b0001;
    end else begin
      long_pulse <= 1'b0;
      if (accept_release || state == RELEASED) begin
        hold <= '0;
        rep  <= '0;
      end else if (state == PRESSED) begin
        if (hold != HOLD_MAX) begin
          hold <= hold + HW'(1);
          if (hold == HOLD_LAST) long_pulse <= 1'b1;
        end else if (rep == REP_MAX) begin
          rep <= '0;
        end else begin
          rep <= rep + RW'(1);
        end
      end
      step_idx <= step_next;
      leds     <= led_onehot(step_next);
    end
  end

  assign LED1 = leds[0];
  assign LED2 = leds[1];
  assign LED3 = leds[2];
  assign LED4 = leds[3];
  assign LED5 = btn_level;

endmodule

// File: tb/tb_button_step_reader.sv
// Self-checking bench: press-pattern table plus event scoreboard and a
// hand-written reset-while-held sequence.
module tb_button_step_reader;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int unsigned REP  = 5;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_STEP  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_raw;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [1:0] step_idx;
  logic       LED1, LED2, LED3, LED4, LED5;

  always #5 clk = ~clk;

  button_step_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .REPEAT_CYCLES  (REP),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .step_idx     (step_idx),
    .LED1         (LED1),
    .LED2         (LED2),
    .LED3         (LED3),
    .LED4         (LED4),
    .LED5         (LED5)
  );

  typedef struct {
    int         cyc;
    int         kind;
    logic [1:0] step;
  } ev_t;

  typedef struct {
    int         low;
    int         high;
    logic [1:0] step;
    logic [3:0] leds;
  } vec_t;

  ev_t        sbq[$];
  vec_t       tbl[11];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [1:0] exp_step = '0;
  logic [1:0] prev_step = '0;
  logic [1:0] mstep = '0;
  logic       exp_level = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_PRESS: return "press";
      K_REL:   return "release";
      K_LONG:  return "long";
      default: return "repeat_step";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic apply_ev(input ev_t e);
    if (e.kind == K_PRESS || e.kind == K_STEP) exp_step = e.step;
    if (e.kind == K_PRESS) exp_level = 1'b1;
    if (e.kind == K_REL)   exp_level = 1'b0;
  endtask

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (sbq.size() > 0 && sbq[0].cyc == cyc && sbq[0].kind == kind) begin
      e = sbq.pop_front();
      check({"step_at_", kname(kind)}, int'(step_idx), int'(e.step));
      apply_ev(e);
    end else begin
      errors++;
      if (sbq.size() > 0)
        $display("FAIL event_%s: got event at cycle %0d, required next %s at cycle %0d",
                 kname(kind), cyc, kname(sbq[0].kind), sbq[0].cyc);
      else
        $display("FAIL event_%s: got event at cycle %0d, required none", kname(kind), cyc);
    end
  endtask

  task automatic monitor();
    logic [3:0] exp_leds;
    if (!rst_n) begin
      exp_step  = '0;
      exp_level = 1'b0;
      prev_step = step_idx;
      return;
    end
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_%s: got nothing by cycle %0d, required at cycle %0d",
               kname(sbq[0].kind), cyc, sbq[0].cyc);
      apply_ev(sbq.pop_front());
    end
    if (press_pulse)   observe(K_PRESS);
    if (release_pulse) observe(K_REL);
    if (long_pulse)    observe(K_LONG);
    if (step_idx != prev_step && !press_pulse) observe(K_STEP);
    prev_step = step_idx;
    exp_leds = 4'b0001 << exp_step;
    check("led_onehot", int'({LED4, LED3, LED2, LED1}), int'(exp_leds));
    check("btn_level", int'(btn_level), int'(exp_level));
    check("led5", int'(LED5), int'(exp_level));
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mon_en) monitor();
  end

  // Expected events for a clean low period of `low` cycles whose first
  // sampling edge is `s`.
  task automatic push_events(input int s, input int low);
    int p, last, l;
    if (low < int'(DEB) + 1) return;
    p = s + 2 + int'(DEB);
    mstep = mstep + 2'd1;
    sbq.push_back('{p, K_PRESS, mstep});
    last = s + low + 2;
    if (p + int'(LONG) - 1 <= last) begin
      l = p + int'(LONG) - 1;
      sbq.push_back('{l, K_LONG, mstep});
      for (int r = l + int'(REP); r <= last; r += int'(REP)) begin
        mstep = mstep + 2'd1;
        sbq.push_back('{r, K_STEP, mstep});
      end
    end
    sbq.push_back('{s + low + 2 + int'(DEB), K_REL, mstep});
  endtask

  task automatic apply_entry(input int low, input int high);
    push_events(cyc + 1, low);
    btn_raw = 1'b0;
    repeat (low) @(negedge clk);
    btn_raw = 1'b1;
    repeat (high) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_step"}, int'(step_idx), 0);
    check({tag, "_leds"}, int'({LED5, LED4, LED3, LED2, LED1}), 1);
    check({tag, "_level"}, int'(btn_level), 0);
    check({tag, "_pulses"}, int'({press_pulse, release_pulse, long_pulse}), 0);
  endtask

  initial begin
    int s;
    tbl = '{
      '{10, 12, 2'd1, 4'b0010},
      '{ 3,  1, 2'd1, 4'b0010},
      '{ 3,  1, 2'd1, 4'b0010},
      '{ 3,  1, 2'd1, 4'b0010},
      '{ 3,  1, 2'd1, 4'b0010},
      '{ 3, 12, 2'd1, 4'b0010},
      '{ 6, 12, 2'd2, 4'b0100},
      '{ 5, 12, 2'd3, 4'b1000},
      '{ 7, 12, 2'd0, 4'b0001},
      '{40, 12, 2'd0, 4'b0001},
      '{ 8, 12, 2'd1, 4'b0010}
    };

    btn_raw = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_sb_drained", sbq.size(), 0);

    for (int i = 0; i < 11; i++) begin
      apply_entry(tbl[i].low, tbl[i].high);
      check($sformatf("tbl%0d_step", i), int'(step_idx), int'(tbl[i].step));
      check($sformatf("tbl%0d_leds", i), int'({LED4, LED3, LED2, LED1}), int'(tbl[i].leds));
      check($sformatf("tbl%0d_sb_drained", i), sbq.size(), 0);
    end

    // Press to step 2, then pulse reset while the button stays held.
    s = cyc + 1;
    mstep = mstep + 2'd1;
    sbq.push_back('{s + 2 + int'(DEB), K_PRESS, mstep});
    btn_raw = 1'b0;
    repeat (10) @(negedge clk);
    check("held_step", int'(step_idx), 2);
    check("held_sb_drained", sbq.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    rst_n = 1'b1;
    mstep = '0;
    push_events(cyc + 1, 10);
    repeat (10) @(negedge clk);
    btn_raw = 1'b1;
    repeat (12) @(negedge clk);
    check("repress_step", int'(step_idx), 1);
    check("repress_leds", int'({LED4, LED3, LED2, LED1}), 4'b0010);
    check("final_sb_drained", sbq.size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
